// File: rtl/key_conditioner.sv
// Push-button front end: per-key 2-FF sync, debounce, and press-edge detection.
// Drives the operating-mode register and auto-repeating plus/sub request pulses.
module key_conditioner #(
  parameter int unsigned DB_CYCLES        = 240_000,
  parameter int unsigned REPEAT_DELAY_CYC = 6_000_000,
  parameter int unsigned REPEAT_RATE_CYC  = 1_200_000,
  parameter bit          ACTIVE_LOW       = 1'b1,
  parameter int unsigned CNT_W            = 23
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_mode_raw,
  input  logic       key_plus_raw,
  input  logic       key_sub_raw,
  output logic [1:0] mode,
  output logic       mode_pulse,
  output logic       plus_pulse,
  output logic       sub_pulse,
  output logic [2:0] pressed
);

  localparam int unsigned K_SUB  = 0;
  localparam int unsigned K_PLUS = 1;
  localparam int unsigned K_MODE = 2;

  localparam logic [2:0]       RAW_RELEASED = ACTIVE_LOW ? 3'b111 : 3'b000;
  localparam logic [CNT_W-1:0] DB_LAST      = CNT_W'(DB_CYCLES - 1);
  localparam logic [CNT_W-1:0] DELAY_LAST   = CNT_W'(REPEAT_DELAY_CYC - 1);
  localparam logic [CNT_W-1:0] RATE_LAST    = CNT_W'(REPEAT_RATE_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_MAX      = '1;

  typedef enum logic [1:0] {
    REP_IDLE,
    REP_HOLD,
    REP_REPEAT
  } rep_state_t;

  logic [2:0]       raw_keys;
  logic [2:0]       sync1;
  logic [2:0]       sync2;
  logic [2:0]       key_lvl;
  logic [2:0]       db_lvl;
  logic [2:0]       db_lvl_d;
  logic [CNT_W-1:0] db_cnt [3];
  logic [1:0]       warm;
  logic [2:0]       armed;
  logic [2:0]       press_edge;
  logic             conflict;

  rep_state_t       rep_state     [2];
  rep_state_t       rep_state_nxt [2];
  logic [CNT_W-1:0] rep_tmr       [2];
  logic [CNT_W-1:0] rep_tmr_nxt   [2];
  logic [1:0]       rep_pulse_nxt;

  assign raw_keys = {key_mode_raw, key_plus_raw, key_sub_raw};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= RAW_RELEASED;
      sync2 <= RAW_RELEASED;
    end else begin
      sync1 <= raw_keys;
      sync2 <= sync1;
    end
  end

  assign key_lvl = ACTIVE_LOW ? ~sync2 : sync2;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      db_lvl   <= '0;
      db_lvl_d <= '0;
      for (int unsigned k = 0; k < 3; k++) begin
        db_cnt[k] <= '0;
      end
    end else begin
      db_lvl_d <= db_lvl;
      for (int unsigned k = 0; k < 3; k++) begin
        if (key_lvl[k] == db_lvl[k]) begin
          db_cnt[k] <= '0;
        end else if (db_cnt[k] == DB_LAST) begin
          db_lvl[k] <= key_lvl[k];
          db_cnt[k] <= '0;
        end else if (db_cnt[k] != CNT_MAX) begin
          db_cnt[k] <= db_cnt[k] + CNT_W'(1);
        end
      end
    end
  end

  // A key arms only once the synchroniser holds real samples and shows it
  // released, so a key held through reset cannot fire until re-pressed.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      warm  <= '0;
      armed <= '0;
    end else begin
      warm <= {warm[0], 1'b1};
      for (int unsigned k = 0; k < 3; k++) begin
        if (warm[1] && !key_lvl[k] && !db_lvl[k]) begin
          armed[k] <= 1'b1;
        end
      end
    end
  end

  assign press_edge = db_lvl & ~db_lvl_d & armed;
  assign conflict   = db_lvl[K_PLUS] & db_lvl[K_SUB];
  assign pressed    = db_lvl;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode       <= 2'b00;
      mode_pulse <= 1'b0;
    end else begin
      mode_pulse <= press_edge[K_MODE];
      if (press_edge[K_MODE]) begin
        mode <= mode + 2'd1;
      end
    end
  end

  // Index 0 is sub, index 1 is plus, matching the db_lvl bit positions.
  always_comb begin
    rep_pulse_nxt = '0;
    for (int unsigned j = 0; j < 2; j++) begin
      rep_state_nxt[j] = rep_state[j];
      rep_tmr_nxt[j]   = rep_tmr[j];
    end
    for (int unsigned j = 0; j < 2; j++) begin
      if (conflict) begin
        rep_state_nxt[j] = REP_IDLE;
        rep_tmr_nxt[j]   = '0;
      end else begin
        case (rep_state[j])
          REP_IDLE: begin
            if (press_edge[j]) begin
              rep_pulse_nxt[j] = 1'b1;
              rep_tmr_nxt[j]   = '0;
              rep_state_nxt[j] = REP_HOLD;
            end
          end
          REP_HOLD: begin
            if (!db_lvl[j]) begin
              rep_state_nxt[j] = REP_IDLE;
              rep_tmr_nxt[j]   = '0;
            end else if (rep_tmr[j] == DELAY_LAST) begin
              rep_pulse_nxt[j] = 1'b1;
              rep_tmr_nxt[j]   = '0;
              rep_state_nxt[j] = REP_REPEAT;
            end else if (rep_tmr[j] != CNT_MAX) begin
              rep_tmr_nxt[j] = rep_tmr[j] + CNT_W'(1);
            end
          end
          REP_REPEAT: begin
            if (!db_lvl[j]) begin
              rep_state_nxt[j] = REP_IDLE;
              rep_tmr_nxt[j]   = '0;
            end else if (rep_tmr[j] == RATE_LAST) begin
              rep_pulse_nxt[j] = 1'b1;
              rep_tmr_nxt[j]   = '0;
            end else if (rep_tmr[j] != CNT_MAX) begin
              rep_tmr_nxt[j] = rep_tmr[j] + CNT_W'(1);
            end
          end
          default: begin
            rep_state_nxt[j] = REP_IDLE;
            rep_tmr_nxt[j]   = '0;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned j = 0; j < 2; j++) begin
        rep_state[j] <= REP_IDLE;
        rep_tmr[j]   <= '0;
      end
      plus_pulse <= 1'b0;
      sub_pulse  <= 1'b0;
    end else begin
      for (int unsigned j = 0; j < 2; j++) begin
        rep_state[j] <= rep_state_nxt[j];
        rep_tmr[j]   <= rep_tmr_nxt[j];
      end
      plus_pulse <= rep_pulse_nxt[K_PLUS];
      sub_pulse  <= rep_pulse_nxt[K_SUB];
    end
  end

endmodule

// File: tb/tb_key_conditioner.sv
// Bench for key_conditioner: vector table, directed corner sequences and
// random key activity checked every cycle against a rule-level model.
module tb_key_conditioner;

  localparam int DB = 4;
  localparam int RD = 20;
  localparam int RR = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       key_mode_raw = 1'b1;
  logic       key_plus_raw = 1'b1;
  logic       key_sub_raw = 1'b1;
  logic [1:0] mode;
  logic       mode_pulse;
  logic       plus_pulse;
  logic       sub_pulse;
  logic [2:0] pressed;

  key_conditioner #(
    .DB_CYCLES       (DB),
    .REPEAT_DELAY_CYC(RD),
    .REPEAT_RATE_CYC (RR),
    .ACTIVE_LOW      (1'b1),
    .CNT_W           (8)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_mode_raw(key_mode_raw),
    .key_plus_raw(key_plus_raw),
    .key_sub_raw (key_sub_raw),
    .mode        (mode),
    .mode_pulse  (mode_pulse),
    .plus_pulse  (plus_pulse),
    .sub_pulse   (sub_pulse),
    .pressed     (pressed)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int n_mpulse = 0;
  int plus_q[$];
  int sub_q[$];

  // Reference model: keys as {mode,plus,sub}, 1 = pressed once normalised.
  bit [2:0]   m_raw_d1, m_raw_d2;
  bit [2:0]   m_stable, m_stable_prev, m_arm;
  int         m_run[3];
  int         m_since_rst;
  logic [1:0] m_mode;
  logic       m_mp;
  logic [1:0] m_rep;
  bit         m_held[2];
  int         m_age[2];

  typedef struct {
    logic [2:0] keys;
    int         hold;
    int         exp_plus;
    int         exp_sub;
    int         exp_mp;
    logic [1:0] exp_mode;
  } vec_t;
  vec_t vecs[10];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_keys(input logic [2:0] k);
    {key_mode_raw, key_plus_raw, key_sub_raw} = k;
  endtask

  function automatic void model_reset();
    m_raw_d1 = 3'b111;
    m_raw_d2 = 3'b111;
    m_stable = '0;
    m_stable_prev = '0;
    m_arm = '0;
    m_since_rst = 0;
    m_mode = 2'b00;
    m_mp = 1'b0;
    m_rep = 2'b00;
    for (int k = 0; k < 3; k++) m_run[k] = 0;
    for (int j = 0; j < 2; j++) begin
      m_held[j] = 1'b0;
      m_age[j] = 0;
    end
  endfunction

  function automatic void model_step();
    bit [2:0] lvl;
    bit [2:0] press;
    bit       both;
    lvl   = ~m_raw_d2;
    press = m_stable & ~m_stable_prev & m_arm;
    m_mp  = press[2];
    if (press[2]) m_mode = m_mode + 2'd1;
    both  = m_stable[1] & m_stable[0];
    m_rep = 2'b00;
    for (int j = 0; j < 2; j++) begin
      if (both) begin
        m_held[j] = 1'b0;
      end else if (m_held[j] && !m_stable[j]) begin
        m_held[j] = 1'b0;
      end else if (!m_held[j]) begin
        if (press[j]) begin
          m_held[j] = 1'b1;
          m_age[j] = 0;
          m_rep[j] = 1'b1;
        end
      end else begin
        m_age[j]++;
        m_rep[j] = (m_age[j] == RD) || (m_age[j] > RD && (m_age[j] - RD) % RR == 0);
      end
    end
    for (int k = 0; k < 3; k++)
      if (m_since_rst >= 2 && !lvl[k] && !m_stable[k]) m_arm[k] = 1'b1;
    m_stable_prev = m_stable;
    for (int k = 0; k < 3; k++) begin
      if (lvl[k] == m_stable[k]) begin
        m_run[k] = 0;
      end else begin
        m_run[k]++;
        if (m_run[k] == DB) begin
          m_stable[k] = lvl[k];
          m_run[k] = 0;
        end
      end
    end
    if (m_since_rst < 4) m_since_rst++;
    m_raw_d2 = m_raw_d1;
    m_raw_d1 = {key_mode_raw, key_plus_raw, key_sub_raw};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
    if (!rst_n) model_reset();
    else model_step();
    check($sformatf("model@%0d", cyc), {mode, mode_pulse, plus_pulse, sub_pulse, pressed},
          {m_mode, m_mp, m_rep[1], m_rep[0], m_stable});
    if (plus_pulse) plus_q.push_back(cyc);
    if (sub_pulse) sub_q.push_back(cyc);
    if (mode_pulse) n_mpulse++;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset();
    set_keys(3'b111);
    rst_n = 1'b0;
    ticks(3);
    rst_n = 1'b1;
    ticks(6);
    plus_q.delete();
    sub_q.delete();
    n_mpulse = 0;
  endtask

  initial begin
    int s;
    int m0;
    int exp_q[$];
    int run[3];
    bit [2:0] lv;
    bit seen;

    vecs[0] = '{3'b101,  3, 0, 0, 0, 2'd0};
    vecs[1] = '{3'b101, 10, 1, 0, 0, 2'd0};
    vecs[2] = '{3'b101, 21, 2, 0, 0, 2'd0};
    vecs[3] = '{3'b101, 20, 1, 0, 0, 2'd0};
    vecs[4] = '{3'b110, 26, 0, 3, 0, 2'd0};
    vecs[5] = '{3'b110, 25, 0, 2, 0, 2'd0};
    vecs[6] = '{3'b011, 10, 0, 0, 1, 2'd1};
    vecs[7] = '{3'b011, 40, 0, 0, 1, 2'd2};
    vecs[8] = '{3'b100, 30, 0, 0, 0, 2'd2};
    vecs[9] = '{3'b001, 10, 1, 0, 1, 2'd3};

    model_reset();
    tick();
    check("reset_state", {mode, mode_pulse, plus_pulse, sub_pulse, pressed}, 0);
    do_reset();

    for (int i = 0; i < 10; i++) begin
      int p0, s0, mp0;
      p0 = plus_q.size();
      s0 = sub_q.size();
      mp0 = n_mpulse;
      set_keys(vecs[i].keys);
      ticks(vecs[i].hold);
      set_keys(3'b111);
      ticks(30);
      check($sformatf("vec%0d_plus", i), plus_q.size() - p0, vecs[i].exp_plus);
      check($sformatf("vec%0d_sub", i), sub_q.size() - s0, vecs[i].exp_sub);
      check($sformatf("vec%0d_mpulse", i), n_mpulse - mp0, vecs[i].exp_mp);
      check($sformatf("vec%0d_mode", i), int'(mode), int'(vecs[i].exp_mode));
    end

    // Bounce, then a clean hold: one pulse DB+3 edges after the final edge.
    do_reset();
    for (int i = 0; i < 20; i++) begin
      key_plus_raw = ((i / 2) % 2 == 0) ? 1'b0 : 1'b1;
      tick();
    end
    check("bounce_no_pulse", plus_q.size(), 0);
    key_plus_raw = 1'b0;
    s = cyc;
    ticks(15);
    key_plus_raw = 1'b1;
    ticks(30);
    check("bounce_count", plus_q.size(), 1);
    if (plus_q.size() > 0) check("bounce_latency", plus_q[0] - s, DB + 3);

    // Mode cycling.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      key_mode_raw = 1'b0;
      ticks(50);
      check($sformatf("mode_step%0d", i), int'(mode), (i + 1) % 4);
      key_mode_raw = 1'b1;
      ticks(50);
    end
    check("mode_pulses", n_mpulse, 4);
    m0 = n_mpulse;
    key_mode_raw = 1'b0;
    ticks(100);
    key_mode_raw = 1'b1;
    ticks(30);
    check("mode_long_hold", n_mpulse - m0, 1);
    check("mode_after_hold", int'(mode), 1);

    // Auto-repeat timing on sub.
    do_reset();
    s = cyc;
    key_sub_raw = 1'b0;
    ticks(60);
    key_sub_raw = 1'b1;
    ticks(40);
    exp_q.delete();
    exp_q.push_back(s + DB + 3);
    for (int t = s + DB + 3 + RD; t <= s + 60 + DB + 2; t += RR) exp_q.push_back(t);
    check("repeat_count", sub_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < sub_q.size(); i++)
      check($sformatf("repeat_time%0d", i), sub_q[i], exp_q[i]);

    // Conflict: sub joins 30 cycles into a plus hold.
    do_reset();
    s = cyc;
    key_plus_raw = 1'b0;
    ticks(30);
    key_sub_raw = 1'b0;
    ticks(30);
    key_sub_raw = 1'b1;
    ticks(40);
    check("conflict_plus_count", plus_q.size(), 3);
    if (plus_q.size() == 3) check("conflict_last_plus", plus_q[2], s + DB + 3 + RD + RR);
    check("conflict_sub_count", sub_q.size(), 0);
    key_plus_raw = 1'b1;
    ticks(30);
    key_plus_raw = 1'b0;
    ticks(10);
    key_plus_raw = 1'b1;
    ticks(30);
    check("conflict_repress", plus_q.size(), 4);

    // Reset during plus auto-repeat, key still held afterwards.
    do_reset();
    key_mode_raw = 1'b0;
    ticks(10);
    key_mode_raw = 1'b1;
    ticks(30);
    key_plus_raw = 1'b0;
    ticks(35);
    rst_n = 1'b0;
    #1;
    model_reset();
    check("midreset_outputs", {mode, mode_pulse, plus_pulse, sub_pulse, pressed}, 0);
    ticks(3);
    rst_n = 1'b1;
    plus_q.delete();
    ticks(40);
    check("midreset_no_pulse", plus_q.size(), 0);
    check("midreset_pressed", int'(pressed[1]), 1);
    key_plus_raw = 1'b1;
    ticks(30);
    check("midreset_release_no_pulse", plus_q.size(), 0);
    key_plus_raw = 1'b0;
    ticks(10);
    key_plus_raw = 1'b1;
    ticks(30);
    check("midreset_repress", plus_q.size(), 1);

    // Glitch shorter than the debounce window.
    do_reset();
    seen = 1'b0;
    key_plus_raw = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (pressed[1]) seen = 1'b1;
    end
    key_plus_raw = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (pressed[1]) seen = 1'b1;
    end
    check("glitch_pulse", plus_q.size(), 0);
    check("glitch_pressed", int'(seen), 0);

    // Random key activity with one asynchronous reset in the middle.
    do_reset();
    lv = 3'b111;
    for (int k = 0; k < 3; k++) run[k] = int'($urandom_range(1, 45));
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < 3; k++) begin
        if (run[k] == 0) begin
          lv[k] = ~lv[k];
          run[k] = int'($urandom_range(1, 45));
        end else begin
          run[k]--;
        end
      end
      set_keys(lv);
      if (i == 1500) begin
        rst_n = 1'b0;
        #1;
        model_reset();
        check("rand_reset", {mode, mode_pulse, plus_pulse, sub_pulse, pressed}, 0);
        tick();
        tick();
        rst_n = 1'b1;
      end
      tick();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
